uart_cmd_frame_tx: RTL and testbench

//  Host/peer-side initiator of the badge UART command protocol. Latches one command and serialises it as a framed 8N1 byte stream.
//  A frame is the mode byte, then 1 or 16 body bytes, then the mode byte again as the end character.

---
 rtl/uart_cmd_frame_tx_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_cmd_frame_tx.sv | 137 +++++++++++++
 tb/tb_uart_cmd_frame_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_frame_tx_pkg.sv
// Shared definitions for the badge UART command protocol.
//   - mode / end-character constants and the flag-reset argument
//   - frame lengths in bytes (short and long)
//   - transmit FSM state encoding
package uart_cmd_frame_tx_pkg;

  localparam logic [7:0] MODE_SEND_TX   = 8'h40;  // "@"
  localparam logic [7:0] MODE_FLAGS     = 8'h41;  // "A"
  localparam logic [7:0] MODE_KEY       = 8'h42;  // "B"
  localparam logic [7:0] MODE_PLAINTEXT = 8'h43;  // "C"
  localparam logic [7:0] ARG_FLAG_RESET = 8'h60;  // grave accent character

  localparam int unsigned FRAME_LEN_SHORT = 3;
  localparam int unsigned FRAME_LEN_LONG  = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate tick generator shared by the UART TX and RX sides.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous, active-high
//   clear    in  synchronous restart of both counters (bit boundary alignment)
//   tick     out oversample tick, high for one clock every BR_LIMIT clocks
//   bit_end  out high on the tick that completes OVERSAMPLE ticks (end of a bit)
module uart_baud_tick #(
    parameter int unsigned BR_LIMIT   = 672,
    parameter int unsigned BR_BITS    = 10,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic bit_end
);

    localparam int unsigned OS_BITS = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [BR_BITS-1:0] br_cnt;
    logic [OS_BITS-1:0] os_cnt;

    assign tick    = (br_cnt == BR_BITS'(BR_LIMIT - 1));
    assign bit_end = tick && (os_cnt == OS_BITS'(OVERSAMPLE - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            br_cnt <= '0;
            os_cnt <= '0;
        end else if (tick) begin
            br_cnt <= '0;
            os_cnt <= bit_end ? '0 : os_cnt + 1'b1;
        end else begin
            br_cnt <= br_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cmd_frame_tx.sv
// Initiator of the badge UART command protocol: latches one command and
// sends it as an 8N1 frame {mode, body, mode}, body = 1 arg byte (short)
// or LONG_BYTES payload bytes (long, MSB byte first).
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high; aborts any frame in flight
//   cmd_valid    in   send request, taken only while cmd_ready=1
//   cmd_ready    out  high while idle
//   cmd_mode     in   mode / end byte
//   cmd_short    in   1: 3-byte frame, 0: long frame
//   cmd_arg      in   body byte of a short frame
//   cmd_payload  in   body of a long frame, [top byte] sent first
//   tx           out  registered serial line, idle high
//   busy         out  inverse of cmd_ready
//   frame_done   out  one-cycle pulse once the last stop bit has completed
module uart_cmd_frame_tx
    import uart_cmd_frame_tx_pkg::*;
#(
    parameter int unsigned BR_LIMIT   = 672,
    parameter int unsigned BR_BITS    = 10,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned LONG_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [7:0]              cmd_mode,
    input  logic                    cmd_short,
    input  logic [7:0]              cmd_arg,
    input  logic [8*LONG_BYTES-1:0] cmd_payload,
    output logic                    tx,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int unsigned FRAME_BITS = 8 * (LONG_BYTES + 2);
    localparam int unsigned IDX_BITS   = $clog2(LONG_BYTES + 2);

    tx_state_e             state, state_nxt;
    logic [FRAME_BITS-1:0] frame_reg;
    logic [IDX_BITS-1:0]   byte_idx;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift_reg;
    logic                  tx_nxt;
    logic                  accept;
    logic                  tick;
    logic                  bit_end;
    logic                  bit_tick;

    // Counters are held at zero while idle so the first bit is aligned to accept.
    uart_baud_tick #(
        .BR_LIMIT  (BR_LIMIT),
        .BR_BITS   (BR_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == ST_IDLE),
        .tick   (tick),
        .bit_end(bit_end)
    );

    assign bit_tick = bit_end & tick;

    always_comb begin
        state_nxt  = state;
        tx_nxt     = 1'b1;
        accept     = 1'b0;
        cmd_ready  = 1'b0;
        frame_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                tx_nxt = 1'b0;
                if (bit_tick) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                tx_nxt = shift_reg[0];
                if (bit_tick && bit_cnt == 3'd7) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (bit_tick) state_nxt = (byte_idx == '0) ? ST_DONE : ST_START;
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = ~cmd_ready;

    // tx is driven from the current state, so the line lags the FSM by one
    // clock; every bit still lasts exactly one bit period.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            tx        <= 1'b1;
            frame_reg <= '0;
            byte_idx  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state <= state_nxt;
            tx    <= tx_nxt;
            if (accept) begin
                if (cmd_short) begin
                    frame_reg <= FRAME_BITS'({cmd_mode, cmd_arg, cmd_mode});
                    byte_idx  <= IDX_BITS'(FRAME_LEN_SHORT - 1);
                end else begin
                    frame_reg <= {cmd_mode, cmd_payload, cmd_mode};
                    byte_idx  <= IDX_BITS'(LONG_BYTES + 1);
                end
            end
            if (state == ST_START && bit_tick) begin
                shift_reg <= frame_reg[{byte_idx, 3'b000} +: 8];
                bit_cnt   <= '0;
            end
            if (state == ST_DATA && bit_tick) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (state == ST_STOP && bit_tick && byte_idx != '0) begin
                byte_idx <= byte_idx - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_frame_tx.sv
module tb_uart_cmd_frame_tx;
    import uart_cmd_frame_tx_pkg::*;

    localparam int unsigned CLK_PER_BIT = 4;  // BR_LIMIT=2 * OVERSAMPLE=2

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_mode;
    logic         cmd_short;
    logic [7:0]   cmd_arg;
    logic [127:0] cmd_payload;
    logic         tx;
    logic         busy;
    logic         frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_cmd_frame_tx #(
        .BR_LIMIT  (2),
        .BR_BITS   (2),
        .OVERSAMPLE(2),
        .LONG_BYTES(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_short  (cmd_short),
        .cmd_arg    (cmd_arg),
        .cmd_payload(cmd_payload),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [7:0]   mode;
        logic         is_short;
        logic [7:0]   arg;
        logic [127:0] payload;
        logic [4:0]   nbytes;
        logic [143:0] exp_bytes;  // first byte on the line in the most significant used byte
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Call at #1 after a clock edge while idle; returns #1 after the accept edge.
    task automatic accept_cmd(input string tag, input vec_t v, input logic scramble);
        cmd_mode    = v.mode;
        cmd_short   = v.is_short;
        cmd_arg     = v.arg;
        cmd_payload = v.payload;
        cmd_valid   = 1'b1;
        @(posedge clk); #1;
        check({tag, " ready low after accept"}, 32'(cmd_ready), 32'd0);
        check({tag, " busy after accept"}, 32'(busy), 32'd1);
        check({tag, " tx idle on accept edge"}, 32'(tx), 32'd1);
        cmd_valid = 1'b0;
        if (scramble) begin
            cmd_mode    = ~cmd_mode;
            cmd_short   = ~cmd_short;
            cmd_arg     = ~cmd_arg;
            cmd_payload = ~cmd_payload;
        end
    endtask

    // Call #1 after the accept edge; samples each line bit at its middle.
    task automatic decode_frame(input string tag, input int unsigned nbytes, input logic [143:0] exp);
        int unsigned  nbits;
        int unsigned  total;
        logic [179:0] bits;
        int           ready_bad;
        int           done_bad;
        logic [7:0]   got;
        nbits     = 10 * nbytes;
        total     = CLK_PER_BIT * nbits;
        bits      = '1;
        ready_bad = 0;
        done_bad  = 0;
        for (int unsigned c = 1; c <= total + 1; c++) begin
            @(posedge clk); #1;
            if (c == 1) check({tag, " start bit after accept+1"}, 32'(tx), 32'd0);
            if (c >= 3 && (c % 4) == 3 && (c - 3) / 4 < nbits) bits[(c - 3) / 4] = tx;
            if (c <= total && cmd_ready !== 1'b0) ready_bad++;
            if (c < total && frame_done !== 1'b0) done_bad++;
            if (c == total) check({tag, " frame_done pulse"}, 32'(frame_done), 32'd1);
            if (c == total + 1) begin
                check({tag, " frame_done one cycle"}, 32'(frame_done), 32'd0);
                check({tag, " ready after done"}, 32'(cmd_ready), 32'd1);
            end
        end
        for (int unsigned b = 0; b < nbytes; b++) begin
            for (int unsigned j = 0; j < 8; j++) got[j] = bits[10 * b + 1 + j];
            check($sformatf("%s byte%0d", tag, b), 32'(got), 32'(exp[8 * (nbytes - 1 - b) +: 8]));
            check($sformatf("%s framing%0d", tag, b),
                  32'({bits[10 * b], bits[10 * b + 9]}), 32'd1);
        end
        check({tag, " ready low while busy"}, 32'(ready_bad), 32'd0);
        check({tag, " no early frame_done"}, 32'(done_bad), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   bad;
        vec_t v;

        vecs[0] = '{mode: 8'h41, is_short: 1'b1, arg: 8'h43, payload: '0, nbytes: 5'd3,
                    exp_bytes: 144'h41_43_41};
        vecs[1] = '{mode: 8'h42, is_short: 1'b0, arg: 8'h00,
                    payload: 128'h00112233445566778899AABBCCDDEEFF, nbytes: 5'd18,
                    exp_bytes: 144'h42_00_11_22_33_44_55_66_77_88_99_AA_BB_CC_DD_EE_FF_42};
        vecs[2] = '{mode: 8'h40, is_short: 1'b1, arg: 8'h60, payload: '0, nbytes: 5'd3,
                    exp_bytes: 144'h40_60_40};
        vecs[3] = '{mode: 8'h40, is_short: 1'b0, arg: 8'h00, payload: 128'h41, nbytes: 5'd18,
                    exp_bytes: 144'h40_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00_41_40};
        vecs[4] = '{mode: 8'h43, is_short: 1'b1, arg: 8'hFF, payload: '0, nbytes: 5'd3,
                    exp_bytes: 144'h43_FF_43};
        vecs[5] = '{mode: 8'h43, is_short: 1'b1, arg: 8'h00, payload: '0, nbytes: 5'd3,
                    exp_bytes: 144'h43_00_43};

        // Reset and idle
        reset = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_short = 1'b0;
        cmd_arg = '0; cmd_payload = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx", 32'(tx), 32'd1);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || cmd_ready !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("idle 50 cycles", 32'(bad), 32'd0);

        // Vector table: each frame decoded off the line, inputs scrambled after accept
        for (int i = 0; i < 6; i++) begin
            accept_cmd($sformatf("vec%0d", i), vecs[i], 1'b1);
            decode_frame($sformatf("vec%0d", i), int'(vecs[i].nbytes), vecs[i].exp_bytes);
            @(posedge clk); #1;
        end

        // cmd_valid held with a new command during a frame
        accept_cmd("hold", vecs[0], 1'b0);
        cmd_valid = 1'b1; cmd_mode = 8'h43; cmd_short = 1'b1; cmd_arg = 8'h5A;
        decode_frame("hold first", 3, 144'h41_43_41);
        @(posedge clk); #1;
        check("hold second accept", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        decode_frame("hold second", 3, 144'h43_5A_43);
        @(posedge clk); #1;

        // Reset during the 2nd data bit of byte 1 (a 0 bit of 0x60)
        accept_cmd("abort", vecs[2], 1'b0);
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
        end
        check("abort tx before reset", 32'(tx), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort tx after reset", 32'(tx), 32'd1);
        check("abort ready after reset", 32'(cmd_ready), 32'd1);
        check("abort busy after reset", 32'(busy), 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 140; i++) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || frame_done !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        check("abort not resumed", 32'(bad), 32'd0);
        v = vecs[4];
        accept_cmd("post abort", v, 1'b1);
        decode_frame("post abort", 3, 144'h43_FF_43);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
